// File: rtl/snn_infer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : snn_infer_sequencer
// Purpose  : Sample-level inference controller for the 30-30-30-5 ECG spiking
//            network. Accepts one spike frame per timestep (valid/ready),
//            drives the network's start/done handshake for T_STEPS timesteps,
//            accumulates saturating per-class spike counts, and picks the
//            winning class with a one-class-per-cycle argmax.
// Ports    : clk, rst_n (async, active low)
//            sample_start                         - begin sample (IDLE only)
//            frame_valid/frame_bits/frame_ready   - input frame handshake
//            net_start/net_spikes_in              - timestep request to network
//            net_done/net_spikes_out              - timestep completion
//            busy, result_valid, result_class,
//            result_counts, wdog_err              - status and result
// Options  : define SNN_SEQ_WATCHDOG_EN to enable the RUN-state watchdog
//            (WDOG_CYCLES cycles per timestep); otherwise wdog_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module snn_infer_sequencer #(
  parameter int N_IN        = 30,
  parameter int N_CLS       = 5,
  parameter int T_STEPS     = 32,
  parameter int CNT_W       = 6,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_start,
  input  logic                   frame_valid,
  input  logic [N_IN-1:0]        frame_bits,
  output logic                   frame_ready,
  output logic                   net_start,
  output logic [N_IN-1:0]        net_spikes_in,
  input  logic                   net_done,
  input  logic [N_CLS-1:0]       net_spikes_out,
  output logic                   busy,
  output logic                   result_valid,
  output logic [2:0]             result_class,
  output logic [N_CLS*CNT_W-1:0] result_counts,
  output logic                   wdog_err
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_frame  = 3'd1;
  localparam logic [2:0] c_st_kick   = 3'd2;
  localparam logic [2:0] c_st_run    = 3'd3;
  localparam logic [2:0] c_st_argmax = 3'd4;
  localparam logic [2:0] c_st_done   = 3'd5;

  localparam logic [7:0]       c_last_step = 8'(T_STEPS - 1);
  localparam logic [2:0]       c_last_cls  = 3'(N_CLS - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  logic [2:0]                  r_state;
  logic [2:0]                  w_state_nxt;
  logic [7:0]                  r_step;
  logic [N_CLS-1:0][CNT_W-1:0] r_cnt;
  logic [N_IN-1:0]             r_frame;
  logic [2:0]                  r_idx;
  logic [2:0]                  r_best_idx;
  logic [CNT_W-1:0]            r_best_cnt;
  logic [2:0]                  r_result_class;

  logic       w_start_ok;
  logic       w_take_frame;
  logic       w_step_done;
  logic       w_last_step;
  logic       w_take;
  logic [2:0] w_best_idx_nxt;
  logic       w_wdog_trip;

  assign w_start_ok   = (r_state == c_st_idle) && sample_start;
  assign w_take_frame = (r_state == c_st_frame) && frame_valid;
  assign w_step_done  = (r_state == c_st_run) && net_done;
  assign w_last_step  = (r_step == c_last_step);

  // Strictly-greater replacement keeps the lowest index on ties; an
  // all-zero count vector therefore resolves to class 0.
  assign w_take         = (r_state == c_st_argmax) && (r_cnt[r_idx] > r_best_cnt);
  assign w_best_idx_nxt = w_take ? r_idx : r_best_idx;

  assign net_spikes_in = r_frame;
  assign result_class  = r_result_class;
  assign result_counts = r_cnt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (sample_start) w_state_nxt = c_st_frame;
      c_st_frame:  if (frame_valid)  w_state_nxt = c_st_kick;
      c_st_kick:   w_state_nxt = c_st_run;
      c_st_run: begin
        if (net_done) begin
          w_state_nxt = w_last_step ? c_st_argmax : c_st_frame;
        end else if (w_wdog_trip) begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_argmax: if (r_idx == c_last_cls) w_state_nxt = c_st_done;
      c_st_done:   w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    frame_ready  = 1'b0;
    net_start    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (r_state)
      c_st_idle:  busy         = 1'b0;
      c_st_frame: frame_ready  = 1'b1;
      c_st_kick:  net_start    = 1'b1;
      c_st_done:  result_valid = 1'b1;
      default:    ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: frame capture, step counter, spike counters, argmax scan
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step         <= '0;
      r_cnt          <= '0;
      r_frame        <= '0;
      r_idx          <= '0;
      r_best_idx     <= '0;
      r_best_cnt     <= '0;
      r_result_class <= '0;
    end else begin
      if (w_start_ok) begin
        r_step         <= '0;
        r_cnt          <= '0;
        r_result_class <= '0;
      end

      // The frame register only changes here, so the network input is
      // stable for the whole KICK/RUN window.
      if (w_take_frame) begin
        r_frame <= frame_bits;
      end

      if (w_step_done) begin
        for (int i = 0; i < N_CLS; i++) begin
          if (net_spikes_out[i] && (r_cnt[i] != c_cnt_max)) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        if (w_last_step) begin
          r_idx      <= '0;
          r_best_idx <= '0;
          r_best_cnt <= '0;
        end else begin
          r_step <= r_step + 8'd1;
        end
      end

      if (r_state == c_st_argmax) begin
        r_idx <= r_idx + 3'd1;
        if (w_take) begin
          r_best_idx <= r_idx;
          r_best_cnt <= r_cnt[r_idx];
        end
        // Publish the winner together with the DONE pulse, including the
        // comparison made on the final class.
        if (r_idx == c_last_cls) begin
          r_result_class <= w_best_idx_nxt;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef SNN_SEQ_WATCHDOG_EN
  localparam int                c_wd_w    = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(WDOG_CYCLES - 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_wdog_err;

  // Trips on the WDOG_CYCLES-th RUN cycle that still has no net_done.
  assign w_wdog_trip = (r_state == c_st_run) && !net_done && (r_wd_cnt == c_wd_last);
  assign wdog_err    = r_wdog_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt   <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      // Held at zero outside RUN, so every RUN entry starts a fresh count.
      if (r_state != c_st_run) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      end

      if (w_start_ok) begin
        r_wdog_err <= 1'b0;
      end else if (w_wdog_trip) begin
        r_wdog_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_wdog;

  assign w_unused_wdog = (WDOG_CYCLES > 0);
  assign w_wdog_trip   = 1'b0;
  assign wdog_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_infer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_snn_infer_sequencer
// Purpose  : Scoreboard bench for snn_infer_sequencer. Instance A uses
//            T_STEPS=4/CNT_W=6 with a 5-cycle network model; instance B uses
//            T_STEPS=8/CNT_W=2 for counter saturation. Expected results are
//            queued at stimulus time and popped by per-instance monitors on
//            every result_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_infer_sequencer;

  localparam int LNET_A = 5;
  localparam int LNET_B = 2;

  typedef struct packed {
    logic [2:0]  cls;
    logic [29:0] cnt;
  } exp_a_t;

  typedef struct packed {
    logic [2:0] cls;
    logic [9:0] cnt;
  } exp_b_t;

  logic        clk;
  logic        rst_n;
  logic        frame_valid;
  logic [29:0] frame_bits;

  logic        a_start, a_frame_ready, a_net_start, a_net_done, a_busy;
  logic        a_result_valid, a_wdog_err;
  logic [29:0] a_net_spikes_in, a_result_counts;
  logic [4:0]  a_net_spk;
  logic [2:0]  a_result_class;

  logic        b_start, b_frame_ready, b_net_start, b_net_done, b_busy;
  logic        b_result_valid, b_wdog_err;
  logic [29:0] b_net_spikes_in;
  logic [9:0]  b_result_counts;
  logic [4:0]  b_net_spk;
  logic [2:0]  b_result_class;

  logic [4:0] a_pat [8];
  logic [4:0] b_pat [8];
  int         a_pidx;
  int         b_pidx;
  logic       a_withhold;

  exp_a_t exp_a_q [$];
  exp_b_t exp_b_q [$];

  int n_checks = 0;
  int n_errors = 0;

  snn_infer_sequencer #(
    .N_IN(30), .N_CLS(5), .T_STEPS(4), .CNT_W(6), .WDOG_CYCLES(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_start(a_start),
    .frame_valid(frame_valid), .frame_bits(frame_bits), .frame_ready(a_frame_ready),
    .net_start(a_net_start), .net_spikes_in(a_net_spikes_in),
    .net_done(a_net_done), .net_spikes_out(a_net_spk),
    .busy(a_busy), .result_valid(a_result_valid), .result_class(a_result_class),
    .result_counts(a_result_counts), .wdog_err(a_wdog_err)
  );

  snn_infer_sequencer #(
    .N_IN(30), .N_CLS(5), .T_STEPS(8), .CNT_W(2), .WDOG_CYCLES(64)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_start(b_start),
    .frame_valid(frame_valid), .frame_bits(frame_bits), .frame_ready(b_frame_ready),
    .net_start(b_net_start), .net_spikes_in(b_net_spikes_in),
    .net_done(b_net_done), .net_spikes_out(b_net_spk),
    .busy(b_busy), .result_valid(b_result_valid), .result_class(b_result_class),
    .result_counts(b_result_counts), .wdog_err(b_wdog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_idle(input bit use_b, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (!(use_b ? b_busy : a_busy)) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout_%s actual=busy required=idle within %0d cycles",
               use_b ? "B" : "A", bound);
    end
  endtask

  task automatic wait_net_start_a(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (a_net_start) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL net_start_timeout actual=none required=net_start within %0d cycles", bound);
    end
  endtask

  task automatic pulse_a_start();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic set_a_pat(input logic [4:0] p0, input logic [4:0] p1,
                           input logic [4:0] p2, input logic [4:0] p3);
    a_pat[0] = p0; a_pat[1] = p1; a_pat[2] = p2; a_pat[3] = p3;
    for (int i = 4; i < 8; i++) a_pat[i] = 5'b0;
  endtask

  task automatic run_a(input logic [4:0] p0, input logic [4:0] p1,
                       input logic [4:0] p2, input logic [4:0] p3,
                       input logic [2:0] ecls, input logic [29:0] ecnt);
    set_a_pat(p0, p1, p2, p3);
    exp_a_q.push_back('{cls: ecls, cnt: ecnt});
    frame_valid = 1'b1;
    pulse_a_start();
    wait_idle(1'b0, 200);
  endtask

  // Network model A: done (with the step's spike vector) arrives LNET_A
  // cycles after the cycle in which the network registers net_start.
  initial begin
    a_net_done = 1'b0;
    a_net_spk  = '0;
    a_pidx     = 0;
    forever begin
      @(negedge clk);
      if (a_start && !a_busy) a_pidx = 0;
      if (a_net_start && !a_withhold) begin
        repeat (LNET_A + 1) @(posedge clk);
        #1;
        a_net_done = 1'b1;
        a_net_spk  = (a_pidx < 8) ? a_pat[a_pidx] : 5'b0;
        a_pidx++;
        @(posedge clk);
        #1;
        a_net_done = 1'b0;
        a_net_spk  = '0;
      end
    end
  end

  initial begin
    b_net_done = 1'b0;
    b_net_spk  = '0;
    b_pidx     = 0;
    forever begin
      @(negedge clk);
      if (b_start && !b_busy) b_pidx = 0;
      if (b_net_start) begin
        repeat (LNET_B + 1) @(posedge clk);
        #1;
        b_net_done = 1'b1;
        b_net_spk  = (b_pidx < 8) ? b_pat[b_pidx] : 5'b0;
        b_pidx++;
        @(posedge clk);
        #1;
        b_net_done = 1'b0;
        b_net_spk  = '0;
      end
    end
  end

  // Monitors: every result_valid cycle must match the oldest queued result.
  initial begin
    exp_a_t e;
    forever begin
      @(negedge clk);
      if (a_result_valid) begin
        if (exp_a_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL A_unexpected_result actual=result_valid required=no_pulse");
        end else begin
          e = exp_a_q.pop_front();
          check("A_result_class", a_result_class, e.cls);
          check("A_result_counts", a_result_counts, e.cnt);
        end
      end
    end
  end

  initial begin
    exp_b_t e;
    forever begin
      @(negedge clk);
      if (b_result_valid) begin
        if (exp_b_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL B_unexpected_result actual=result_valid required=no_pulse");
        end else begin
          e = exp_b_q.pop_front();
          check("B_result_class", b_result_class, e.cls);
          check("B_result_counts", b_result_counts, e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;

    rst_n       = 1'b0;
    a_start     = 1'b0;
    b_start     = 1'b0;
    frame_valid = 1'b0;
    frame_bits  = '0;
    a_withhold  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_pat[i] = '0;
      b_pat[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_frame_ready", a_frame_ready, 0);
    check("rst_net_start", a_net_start, 0);
    check("rst_result_valid", a_result_valid, 0);
    check("rst_result_class", a_result_class, 0);
    check("rst_result_counts", a_result_counts, 0);
    check("rst_net_spikes_in", a_net_spikes_in, 0);
    check("rst_wdog_err", a_wdog_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single winning class, with latency counted inclusively from the
    // sample_start cycle to the result_valid cycle: 4*(3+5)+5+2 = 39.
    set_a_pat(5'b00100, 5'b00100, 5'b00100, 5'b00100);
    exp_a_q.push_back('{cls: 3'd2, cnt: {6'd0, 6'd0, 6'd4, 6'd0, 6'd0}});
    frame_valid = 1'b1;
    frame_bits  = 30'h0000_1234;
    pulse_a_start();
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (a_result_valid) break;
    end
    check("latency_cycles", n, 39);
    wait_idle(1'b0, 50);
    repeat (3) @(negedge clk);
    check("held_class", a_result_class, 2);
    check("held_counts", a_result_counts, {6'd0, 6'd0, 6'd4, 6'd0, 6'd0});
    check("idle_busy", a_busy, 0);

    // Tie between classes 1 and 3 resolves to the lower index
    run_a(5'b01010, 5'b01010, 5'b01010, 5'b00000, 3'd1, {6'd0, 6'd3, 6'd0, 6'd3, 6'd0});
    // No spikes: class 0, all counts cleared from the previous sample
    run_a(5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd0, 30'd0);
    // Later class wins only when strictly greater
    run_a(5'b10001, 5'b10000, 5'b01000, 5'b00000, 3'd4, {6'd2, 6'd1, 6'd0, 6'd0, 6'd1});
    run_a(5'b01100, 5'b01100, 5'b01100, 5'b01000, 3'd3, {6'd0, 6'd4, 6'd3, 6'd0, 6'd0});

    // Backpressure, frame stability in RUN, sample_start ignored while busy
    set_a_pat(5'b11111, 5'b11111, 5'b11111, 5'b11111);
    exp_a_q.push_back('{cls: 3'd0, cnt: {6'd4, 6'd4, 6'd4, 6'd4, 6'd4}});
    frame_valid = 1'b0;
    pulse_a_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_frame_ready", a_frame_ready, 1);
      check("bp_no_net_start", a_net_start, 0);
    end
    @(posedge clk); #1 frame_bits = 30'h2AAA_AAAA; frame_valid = 1'b1;
    @(posedge clk); #1 frame_valid = 1'b0; frame_bits = 30'h1555_5555;
    @(negedge clk);
    check("bp_kick_net_start", a_net_start, 1);
    @(posedge clk); #1 a_start = 1'b1; frame_bits = 30'h0F0F_0F0F;
    @(negedge clk);
    check("run_frame_hold_1", a_net_spikes_in, 30'h2AAA_AAAA);
    @(posedge clk); #1 a_start = 1'b0; frame_bits = 30'h3FFF_FFFF;
    @(negedge clk);
    check("run_frame_hold_2", a_net_spikes_in, 30'h2AAA_AAAA);
    check("start_ignored_busy", a_busy, 1);
    frame_valid = 1'b1;
    wait_idle(1'b0, 200);

    // Asynchronous reset in the second RUN phase, then a fresh sample
    set_a_pat(5'b01000, 5'b01000, 5'b01000, 5'b01000);
    pulse_a_start();
    wait_net_start_a(20);
    wait_net_start_a(30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", a_busy, 0);
    check("arst_frame_ready", a_frame_ready, 0);
    check("arst_net_start", a_net_start, 0);
    check("arst_result_valid", a_result_valid, 0);
    check("arst_result_class", a_result_class, 0);
    check("arst_result_counts", a_result_counts, 0);
    check("arst_net_spikes_in", a_net_spikes_in, 0);
    check("arst_wdog_err", a_wdog_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    run_a(5'b00100, 5'b00100, 5'b00100, 5'b00100, 3'd2, {6'd0, 6'd0, 6'd4, 6'd0, 6'd0});

    // Saturation on instance B: class 4 spikes 8 times into a 2-bit counter
    b_pat[0] = 5'b10001;
    b_pat[1] = 5'b10001;
    for (int i = 2; i < 8; i++) b_pat[i] = 5'b10000;
    exp_b_q.push_back('{cls: 3'd4, cnt: {2'd3, 2'd0, 2'd0, 2'd0, 2'd2}});
    frame_valid = 1'b1;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    wait_idle(1'b1, 300);

`ifdef SNN_SEQ_WATCHDOG_EN
    // Withheld net_done: abort after 16 RUN cycles, no result
    a_withhold = 1'b1;
    set_a_pat(5'b00010, 5'b00010, 5'b00010, 5'b00010);
    pulse_a_start();
    wait_net_start_a(20);
    repeat (16) @(negedge clk);
    check("wdog_not_yet", a_wdog_err, 0);
    check("wdog_still_busy", a_busy, 1);
    @(negedge clk);
    check("wdog_err_set", a_wdog_err, 1);
    check("wdog_idle", a_busy, 0);
    repeat (3) @(negedge clk);
    check("wdog_sticky", a_wdog_err, 1);
    a_withhold = 1'b0;
    exp_a_q.push_back('{cls: 3'd1, cnt: {6'd0, 6'd0, 6'd0, 6'd4, 6'd0}});
    pulse_a_start();
    @(negedge clk);
    check("wdog_cleared", a_wdog_err, 0);
    wait_idle(1'b0, 200);
`endif

    repeat (5) @(negedge clk);
    check("A_queue_drained", exp_a_q.size(), 0);
    check("B_queue_drained", exp_b_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
